// File: rtl/wr_cell_gen.sv
// Write-port address generator for one LDPC message RAM bank.
// LOAD streams DEPTH sequential words; UPDATE walks N_OFF rotated circulant blocks.
module wr_cell_gen #(
  parameter int unsigned A_WID = 8,
  parameter int unsigned N_OFF = 3,
  parameter int unsigned Z     = 36,
  parameter int unsigned DEPTH = 216
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_start,
  input  logic                   upd_start,
  input  logic                   abort,
  input  logic                   din_vld,
  input  logic                   wr_en,
  input  logic [A_WID-1:0]       base_addr,
  input  logic [N_OFF*A_WID-1:0] addr_offset,
  output logic [A_WID-1:0]       wr_addr,
  output logic                   ram_wr,
  output logic                   busy,
  output logic                   done,
  output logic                   off_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_UPD} state_t;

  localparam int unsigned       K_W      = (N_OFF > 1) ? $clog2(N_OFF) : 1;
  localparam logic [A_WID:0]    DEPTH_M1 = (A_WID+1)'(DEPTH - 1);
  localparam logic [A_WID:0]    Z_W      = (A_WID+1)'(Z);
  localparam logic [A_WID-1:0]  Z_M1     = A_WID'(Z - 1);
  localparam logic [K_W-1:0]    K_LAST   = K_W'(N_OFF - 1);

  state_t                 state_q, state_d;
  logic [A_WID-1:0]       base_q, base_d;
  logic [N_OFF*A_WID-1:0] off_q, off_d;
  logic [A_WID:0]         wc_q, wc_d;
  logic [K_W-1:0]         k_q, k_d;
  logic [A_WID-1:0]       r_q, r_d;
  logic [A_WID-1:0]       addr_d;
  logic                   wr_d, done_d, err_d;

  logic [A_WID-1:0]       off_arr [N_OFF];
  logic [A_WID-1:0]       off_cur;
  logic [A_WID:0]         s_raw, s_mod;
  logic [A_WID-1:0]       upd_addr, load_addr;

  // Block 0 lives in the most significant slice of the offset bus.
  for (genvar g = 0; g < N_OFF; g++) begin : g_off
    assign off_arr[g] = off_q[(N_OFF-1-g)*A_WID +: A_WID];
  end

  assign off_cur   = off_arr[k_q];
  assign s_raw     = {1'b0, off_cur} + {1'b0, r_q};
  assign s_mod     = (s_raw >= Z_W) ? (s_raw - Z_W) : s_raw;
  assign upd_addr  = base_q + s_mod[A_WID-1:0];
  assign load_addr = base_q + wc_q[A_WID-1:0];
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    off_d   = off_q;
    wc_d    = wc_q;
    k_d     = k_q;
    r_d     = r_q;
    addr_d  = wr_addr;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = off_err;
    if (abort) begin
      state_d = S_IDLE;
      wc_d    = '0;
      k_d     = '0;
      r_d     = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_start) begin
            state_d = S_LOAD;
            base_d  = base_addr;
            wc_d    = '0;
          end else if (upd_start) begin
            state_d = S_UPD;
            base_d  = base_addr;
            off_d   = addr_offset;
            k_d     = '0;
            r_d     = '0;
            err_d   = 1'b0;
          end
        end
        S_LOAD: begin
          if (din_vld) begin
            wr_d   = 1'b1;
            addr_d = load_addr;
            wc_d   = wc_q + 1'b1;
            if (wc_q == DEPTH_M1) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
              wc_d    = '0;
            end
          end
        end
        S_UPD: begin
          if (wr_en) begin
            wr_d   = 1'b1;
            addr_d = upd_addr;
            if ({1'b0, off_cur} >= Z_W) err_d = 1'b1;
            if (r_q == Z_M1) begin
              r_d = '0;
              if (k_q == K_LAST) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                k_d     = '0;
              end else begin
                k_d = k_q + 1'b1;
              end
            end else begin
              r_d = r_q + 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      off_q   <= '0;
      wc_q    <= '0;
      k_q     <= '0;
      r_q     <= '0;
      wr_addr <= '0;
      ram_wr  <= 1'b0;
      done    <= 1'b0;
      off_err <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      off_q   <= off_d;
      wc_q    <= wc_d;
      k_q     <= k_d;
      r_q     <= r_d;
      wr_addr <= addr_d;
      ram_wr  <= wr_d;
      done    <= done_d;
      off_err <= err_d;
    end
  end

endmodule

// File: tb/tb_wr_cell_gen.sv
// Bench for wr_cell_gen: table of LOAD/UPDATE passes feeding a write-address
// scoreboard, plus abort, dual-start and asynchronous-reset sequences.
module tb_wr_cell_gen;

  localparam int unsigned A_WID = 8;
  localparam int unsigned N_OFF = 3;
  localparam int unsigned Z     = 4;
  localparam int unsigned DEPTH = 8;

  logic                   clk;
  logic                   reset;
  logic                   load_start, upd_start, abort, din_vld, wr_en;
  logic [A_WID-1:0]       base_addr;
  logic [N_OFF*A_WID-1:0] addr_offset;
  logic [A_WID-1:0]       wr_addr;
  logic                   ram_wr, busy, done, off_err;

  wr_cell_gen #(.A_WID(A_WID), .N_OFF(N_OFF), .Z(Z), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_start  (load_start),
    .upd_start   (upd_start),
    .abort       (abort),
    .din_vld     (din_vld),
    .wr_en       (wr_en),
    .base_addr   (base_addr),
    .addr_offset (addr_offset),
    .wr_addr     (wr_addr),
    .ram_wr      (ram_wr),
    .busy        (busy),
    .done        (done),
    .off_err     (off_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Each entry: {done expected with this write, address}.
  logic [8:0] exp_q [$];
  logic [8:0] mon_e;

  typedef struct packed {
    logic        upd;
    logic        both;
    logic [7:0]  base;
    logic [23:0] offs;
    logic [15:0] vpat;
    logic [3:0]  n;
    logic [95:0] exp;
    logic        err;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (ram_wr) begin
        check("write_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("wr_addr", wr_addr, mon_e[7:0]);
          check("done_with_write", done, mon_e[8]);
        end
      end else begin
        check("done_without_write", done, 0);
      end
    end
  end

  task automatic idle_inputs();
    load_start = 0; upd_start = 0; abort = 0; din_vld = 0; wr_en = 0;
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned pushed;
    int unsigned cyc;
    logic        bit_v;
    logic [7:0]  a;
    pushed = 0;
    cyc    = 0;
    base_addr   = v.base;
    addr_offset = v.offs;
    load_start  = !v.upd || v.both;
    upd_start   = v.upd || v.both;
    @(posedge clk); #1;
    // Corrupt the bus after the start edge: the pass must use latched values.
    base_addr   = ~v.base;
    addr_offset = ~v.offs;
    while (pushed < v.n && cyc < 64) begin
      bit_v = v.vpat[cyc % 16];
      if (v.upd) begin wr_en = bit_v; din_vld = ~bit_v; end
      else       begin din_vld = bit_v; wr_en = ~bit_v; end
      load_start = bit_v;
      upd_start  = ~bit_v;
      if (bit_v) begin
        a = v.exp[(11 - pushed)*8 +: 8];
        pushed++;
        exp_q.push_back({pushed == v.n, a});
      end
      if (cyc == 0) begin
        @(negedge clk);
        check("busy_in_pass", busy, 1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    check("busy_after_pass", busy, 0);
    check("ram_wr_after_pass", ram_wr, 0);
    check("off_err", off_err, v.err);
    exp_q.delete();
  endtask

  initial begin
    logic [47:0] ab;
    tbl[0] = '{1'b0, 1'b0, 8'h10, 24'h000000, 16'hFFFF, 4'd8,  96'h10111213_14151617_00000000, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 8'h40, 24'h000000, 16'h9999, 4'd8,  96'h40414243_44454647_00000000, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 8'hFE, 24'h000000, 16'hFFFF, 4'd8,  96'hFEFF0001_02030405_00000000, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 8'h20, 24'h010300, 16'hFFFF, 4'd12, 96'h21222320_23202122_20212223, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 8'h20, 24'h050002, 16'hFFFF, 4'd12, 96'h21222324_20212223_22232021, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 8'h80, 24'h000000, 16'hFFFF, 4'd8,  96'h80818283_84858687_00000000, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 8'hFE, 24'h020103, 16'h6B5D, 4'd12, 96'h0001FEFF_FF0001FE_01FEFF00, 1'b0};

    reset = 1'b1;
    idle_inputs();
    base_addr   = '0;
    addr_offset = '0;
    #3;
    check("rst_wr_addr", wr_addr, 0);
    check("rst_ram_wr",  ram_wr, 0);
    check("rst_busy",    busy, 0);
    check("rst_done",    done, 0);
    check("rst_off_err", off_err, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Abort at block 1, row 2 of an UPDATE pass, then restart from block 0.
    ab = 48'h21_22_23_20_23_20;
    base_addr   = 8'h20;
    addr_offset = 24'h010300;
    upd_start   = 1;
    @(posedge clk); #1;
    upd_start = 0;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1;
      exp_q.push_back({1'b0, ab[(5 - i)*8 +: 8]});
      @(posedge clk); #1;
    end
    abort = 1;
    wr_en = 1;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("abort_ram_wr", ram_wr, 0);
    check("abort_busy",   busy, 0);
    check("abort_done",   done, 0);
    check("abort_queue",  exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk); #1;
    run_vec(tbl[3]);

    // Reset asserted while a LOAD write strobe is high.
    base_addr = 8'h30;
    load_start = 1;
    @(posedge clk); #1;
    load_start = 0;
    din_vld = 1;
    exp_q.push_back({1'b0, 8'h30});
    @(posedge clk); #1;
    exp_q.push_back({1'b0, 8'h31});
    @(posedge clk); #1;
    din_vld = 0;
    @(negedge clk); #1;
    check("pre_reset_ram_wr", ram_wr, 1);
    check("pre_reset_busy",   busy, 1);
    reset = 1'b1;
    #1;
    check("async_rst_wr_addr", wr_addr, 0);
    check("async_rst_ram_wr",  ram_wr, 0);
    check("async_rst_busy",    busy, 0);
    check("async_rst_done",    done, 0);
    check("async_rst_off_err", off_err, 0);
    check("async_rst_queue",   exp_q.size(), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("post_rst_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
